// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single data-memory port: the core wins by default,
// the DMA takes idle cycles, and a starvation counter forces one DMA beat.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_addr,
  input  logic        c_re,
  input  logic        c_we,
  input  logic [3:0]  c_wstrb,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        core_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic        m_re,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W:0] LIMIT_EXT = (CNT_W + 1)'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic             d_rvalid_r;
  logic             core_act_s;
  logic             d_gnt_s;
  logic             core_stall_s;

  // Next-state, starvation count and memory-port steering
  always_comb begin
    state_s      = NORMAL;
    starve_cnt_s = starve_cnt_r;
    d_gnt_s      = 1'b0;
    core_stall_s = 1'b0;
    m_addr       = c_addr;
    m_wstrb      = c_wstrb;
    m_wdata      = c_wdata;
    m_re         = 1'b0;
    m_we         = 1'b0;
    core_act_s   = c_re | c_we;
    cnt_inc_s    = {1'b0, starve_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    // Reset also quiets the port and handshakes in the cycle it is asserted.
    if (rst) begin
      starve_cnt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        NORMAL: begin
          if (core_act_s) begin
            // Simultaneous c_re/c_we is resolved as a write.
            m_we = c_we;
            m_re = c_re & ~c_we;
            if (d_req) begin
              if (cnt_inc_s <= LIMIT_EXT) begin
                starve_cnt_s = cnt_inc_s[CNT_W-1:0];
              end else begin
                starve_cnt_s = starve_cnt_r;
              end
              if (cnt_inc_s == LIMIT_EXT) begin
                state_s = FORCE;
              end else begin
                state_s = NORMAL;
              end
            end else begin
              starve_cnt_s = {CNT_W{1'b0}};
            end
          end else if (d_req) begin
            m_addr       = d_addr;
            m_wstrb      = d_wstrb;
            m_wdata      = d_wdata;
            m_we         = d_we;
            m_re         = ~d_we;
            d_gnt_s      = 1'b1;
            starve_cnt_s = {CNT_W{1'b0}};
          end else begin
            starve_cnt_s = {CNT_W{1'b0}};
          end
        end
        FORCE: begin
          core_stall_s = 1'b1;
          starve_cnt_s = {CNT_W{1'b0}};
          // A dropped d_req here leaves the port idle but still stalls the core.
          if (d_req) begin
            m_addr  = d_addr;
            m_wstrb = d_wstrb;
            m_wdata = d_wdata;
            m_we    = d_we;
            m_re    = ~d_we;
            d_gnt_s = 1'b1;
          end else begin
            d_gnt_s = 1'b0;
          end
        end
        default: begin
          state_s      = NORMAL;
          starve_cnt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, starvation counter and DMA read-return flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= NORMAL;
      starve_cnt_r <= {CNT_W{1'b0}};
      d_rvalid_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      d_rvalid_r   <= d_gnt_s & ~d_we;
    end
  end

  assign d_gnt      = d_gnt_s;
  assign core_stall = core_stall_s;
  assign d_rvalid   = d_rvalid_r;
  assign d_rdata    = m_rdata;
  assign c_rdata    = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycles with a DMA read-data scoreboard; a second
// instance with STARVE_LIMIT=1 shares the inputs.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_re, c_we, d_req, d_we;
  logic [3:0]  c_wstrb, d_wstrb;

  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        core_stall, d_gnt, d_rvalid, m_re, m_we;
  logic [3:0]  m_wstrb;

  logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        core_stall1, d_gnt1, d_rvalid1, m_re1, m_we1;
  logic [3:0]  m_wstrb1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wstrb(c_wstrb), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_arbiter #(.STARVE_LIMIT(1)) dut1 (
    .clk(clk), .rst(rst),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wstrb(c_wstrb), .c_wdata(c_wdata),
    .c_rdata(c_rdata1), .core_stall(core_stall1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_addr(m_addr1), .m_re(m_re1), .m_we(m_we1), .m_wstrb(m_wstrb1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1)
  );

  // Read-only memory contents: a fixed word at 0x100, an address pattern elsewhere.
  function automatic logic [31:0] exp_pat(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Synchronous-read memory behind each arbiter
  always @(posedge clk) begin
    if (m_re) m_rdata <= exp_pat(m_addr);
    if (m_re1) m_rdata1 <= m_addr1;
  end

  // Scoreboard: every DMA read return must match the oldest expected word
  always @(negedge clk) begin
    if (d_rvalid === 1'b1) begin
      if (exp_q.size() == 0) check_val("rvalid_unexpected", {31'd0, d_rvalid}, 32'd0);
      else check_val("d_rdata", d_rdata, exp_q.pop_front());
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    c_addr = 32'd0; c_re = 1'b0; c_we = 1'b0; c_wstrb = 4'hF; c_wdata = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wstrb = 4'hF; d_wdata = 32'd0;
    m_rdata = 32'd0; m_rdata1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_val("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check_val("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check_val("rst_m_re", {31'd0, m_re}, 32'd0);
    check_val("rst_m_we", {31'd0, m_we}, 32'd0);
    check_val("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    next_cycle();

    // Core-only read
    c_re = 1'b1; c_addr = 32'h0000_0100;
    @(negedge clk);
    check_val("core_m_addr", m_addr, 32'h0000_0100);
    check_val("core_m_re", {31'd0, m_re}, 32'd1);
    check_val("core_d_gnt", {31'd0, d_gnt}, 32'd0);
    check_val("core_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    c_re = 1'b0;
    @(negedge clk);
    check_val("core_c_rdata", c_rdata, 32'hDEAD_BEEF);
    check_val("core_stall_after", {31'd0, core_stall}, 32'd0);
    next_cycle();

    // DMA read while the core is idle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    exp_q.push_back(exp_pat(32'h0000_0200));
    @(negedge clk);
    check_val("dma_rd_gnt", {31'd0, d_gnt}, 32'd1);
    check_val("dma_rd_m_re", {31'd0, m_re}, 32'd1);
    check_val("dma_rd_m_we", {31'd0, m_we}, 32'd0);
    check_val("dma_rd_m_addr", m_addr, 32'h0000_0200);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check_val("dma_rd_rvalid", {31'd0, d_rvalid}, 32'd1);
    next_cycle();

    // DMA write with partial strobes
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
    @(negedge clk);
    check_val("dma_wr_gnt", {31'd0, d_gnt}, 32'd1);
    check_val("dma_wr_m_we", {31'd0, m_we}, 32'd1);
    check_val("dma_wr_m_re", {31'd0, m_re}, 32'd0);
    check_val("dma_wr_m_wstrb", {28'd0, m_wstrb}, 32'h0000_0003);
    check_val("dma_wr_m_wdata", m_wdata, 32'h1234_5678);
    check_val("dma_wr_m_addr", m_addr, 32'h0000_0300);
    next_cycle();

    // Back-to-back DMA reads; the preceding write must not return data
    d_we = 1'b0; d_addr = 32'h0000_0400; d_wstrb = 4'hF;
    exp_q.push_back(exp_pat(32'h0000_0400));
    @(negedge clk);
    check_val("b2b_gnt0", {31'd0, d_gnt}, 32'd1);
    check_val("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    next_cycle();
    d_addr = 32'h0000_0404;
    exp_q.push_back(exp_pat(32'h0000_0404));
    @(negedge clk);
    check_val("b2b_gnt1", {31'd0, d_gnt}, 32'd1);
    check_val("b2b_rvalid0", {31'd0, d_rvalid}, 32'd1);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check_val("b2b_rvalid1", {31'd0, d_rvalid}, 32'd1);
    next_cycle();

    // Contention: eight denied cycles, then one forced DMA beat
    c_re = 1'b1; c_addr = 32'h0000_0500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("cont_deny_gnt", {31'd0, d_gnt}, 32'd0);
      check_val("cont_deny_stall", {31'd0, core_stall}, 32'd0);
      check_val("cont_deny_m_addr", m_addr, 32'h0000_0500);
      next_cycle();
    end
    exp_q.push_back(exp_pat(32'h0000_0600));
    @(negedge clk);
    check_val("force_stall", {31'd0, core_stall}, 32'd1);
    check_val("force_gnt", {31'd0, d_gnt}, 32'd1);
    check_val("force_m_addr", m_addr, 32'h0000_0600);
    check_val("force_m_re", {31'd0, m_re}, 32'd1);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check_val("post_force_stall", {31'd0, core_stall}, 32'd0);
    check_val("post_force_m_addr", m_addr, 32'h0000_0500);
    check_val("post_force_m_re", {31'd0, m_re}, 32'd1);
    next_cycle();
    c_re = 1'b0;
    next_cycle();

    // Core goes idle on the fifth contention cycle; the counter must restart
    c_re = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0610;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("idle5_deny_gnt", {31'd0, d_gnt}, 32'd0);
      next_cycle();
    end
    c_re = 1'b0;
    exp_q.push_back(exp_pat(32'h0000_0610));
    @(negedge clk);
    check_val("idle5_gnt", {31'd0, d_gnt}, 32'd1);
    check_val("idle5_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    c_re = 1'b1; d_addr = 32'h0000_0620;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("idle5_no_force", {31'd0, core_stall}, 32'd0);
      check_val("idle5_after_gnt", {31'd0, d_gnt}, 32'd0);
      next_cycle();
    end
    c_re = 1'b0; d_req = 1'b0;
    next_cycle();

    // Reset the cycle after a DMA read grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
    exp_q.push_back(exp_pat(32'h0000_0700));
    @(negedge clk);
    check_val("rst_op_gnt", {31'd0, d_gnt}, 32'd1);
    next_cycle();
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check_val("rst_op_in_gnt", {31'd0, d_gnt}, 32'd0);
    check_val("rst_op_in_m_re", {31'd0, m_re}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_op_rvalid", {31'd0, d_rvalid}, 32'd0);
    check_val("rst_op_stall", {31'd0, core_stall}, 32'd0);
    check_val("rst_op_m_re", {31'd0, m_re}, 32'd0);
    check_val("rst_op_m_we", {31'd0, m_we}, 32'd0);
    next_cycle();

    // Reset mid-contention clears the starvation count
    c_re = 1'b1; c_addr = 32'h0000_0500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0800; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
    repeat (5) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_cont_stall", {31'd0, core_stall}, 32'd0);
    check_val("rst_cont_gnt", {31'd0, d_gnt}, 32'd0);
    check_val("rst_cont_m_we", {31'd0, m_we}, 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("rst_cont_deny_stall", {31'd0, core_stall}, 32'd0);
      check_val("rst_cont_deny_gnt", {31'd0, d_gnt}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_val("rst_cont_force_stall", {31'd0, core_stall}, 32'd1);
    check_val("rst_cont_force_gnt", {31'd0, d_gnt}, 32'd1);
    check_val("rst_cont_force_m_we", {31'd0, m_we}, 32'd1);
    check_val("rst_cont_force_m_addr", m_addr, 32'h0000_0800);
    check_val("rst_cont_force_m_wdata", m_wdata, 32'hCAFE_F00D);
    next_cycle();
    c_re = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_val("rst_cont_after_stall", {31'd0, core_stall}, 32'd0);
    next_cycle();
    next_cycle();

    // STARVE_LIMIT=1 instance: forced beat on every second cycle
    c_re = 1'b1; c_addr = 32'h0000_0500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0900; d_wdata = 32'h0BAD_CAFE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check_val("lim1_core_stall", {31'd0, core_stall1}, 32'd0);
        check_val("lim1_core_gnt", {31'd0, d_gnt1}, 32'd0);
        check_val("lim1_core_m_addr", m_addr1, 32'h0000_0500);
        check_val("lim1_core_m_re", {31'd0, m_re1}, 32'd1);
      end else begin
        check_val("lim1_force_stall", {31'd0, core_stall1}, 32'd1);
        check_val("lim1_force_gnt", {31'd0, d_gnt1}, 32'd1);
        check_val("lim1_force_m_addr", m_addr1, 32'h0000_0900);
        check_val("lim1_force_m_we", {31'd0, m_we1}, 32'd1);
      end
      next_cycle();
    end

    // Forced cycle with d_req dropped: no access, core still stalled
    @(negedge clk);
    check_val("drop_deny_stall", {31'd0, core_stall1}, 32'd0);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check_val("drop_force_stall", {31'd0, core_stall1}, 32'd1);
    check_val("drop_force_gnt", {31'd0, d_gnt1}, 32'd0);
    check_val("drop_force_m_re", {31'd0, m_re1}, 32'd0);
    check_val("drop_force_m_we", {31'd0, m_we1}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_val("drop_after_stall", {31'd0, core_stall1}, 32'd0);
    check_val("drop_after_m_re", {31'd0, m_re1}, 32'd1);
    next_cycle();
    c_re = 1'b0;
    repeat (3) next_cycle();

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single data-memory port between two requesters: the core load/store path and a secondary DMA/loader requester.
- The core is the primary requester and is granted by default.
- A DMA request wins any cycle the core is idle.
- A starvation counter guarantees the DMA one forced beat after STARVE_LIMIT lost cycles. The arbiter asserts core_stall for that beat.
- Sits between core's bus_* port and the RAM, which has synchronous read (data returned one cycle after m_re).

Parameters:
- STARVE_LIMIT, 8, consecutive denied DMA cycles before a forced DMA beat (legal range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c_addr  in  32  core address
- c_re  in  1  core read request
- c_we  in  1  core write request
- c_wstrb  in  4  core byte strobes
- c_wdata  in  32  core write data
- c_rdata  out  32  core read data
- core_stall  out  1  core must hold its request unchanged this cycle
- d_req  in  1  DMA request, held until d_gnt
- d_we  in  1  DMA write (0 = read), qualified by d_req
- d_addr  in  32  DMA address
- d_wstrb  in  4  DMA byte strobes
- d_wdata  in  32  DMA write data
- d_gnt  out  1  DMA beat accepted this cycle
- d_rvalid  out  1  DMA read data valid
- d_rdata  out  32  DMA read data
- m_addr  out  32  memory address
- m_re  out  1  memory read enable
- m_we  out  1  memory write enable
- m_wstrb  out  4  memory byte strobes
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid cycle after m_re

Behaviour:
- States: NORMAL and FORCE, plus starve_cnt of width $clog2(STARVE_LIMIT+1).
- Reset (synchronous, any cycle, including mid-beat):
  - state=NORMAL, starve_cnt=0, d_rvalid=0.
  - core_stall=0, d_gnt=0, m_re=0, m_we=0.
  - A beat in flight at reset is discarded; no d_rvalid follows it.
- Core active is defined as c_re|c_we. c_re and c_we together is illegal; the arbiter then treats the request as a write.
- NORMAL, core active: m_* are driven from c_* (combinational, same cycle); d_gnt=0; core_stall=0.
- NORMAL, core idle and d_req=1:
  - m_addr/m_wstrb/m_wdata are driven from d_*; m_we=d_we; m_re=~d_we.
  - d_gnt=1; starve_cnt cleared.
- NORMAL, core idle and d_req=0: m_re=m_we=0; m_addr is don't-care, driven from c_addr.
- starve_cnt:
  - Increments on each cycle with d_req=1 and d_gnt=0.
  - Clears on d_gnt or when d_req=0.
  - Saturates at STARVE_LIMIT.
- Transition NORMAL->FORCE at a clock edge when starve_cnt+1 == STARVE_LIMIT and the DMA is denied that cycle.
- FORCE lasts exactly one cycle:
  - core_stall=1.
  - The DMA is granted regardless of core activity; m_* are driven from d_*; d_gnt=1.
  - The core's request is ignored that cycle and is not queued. The core re-presents it because it holds while core_stall is high.
  - Next state is NORMAL with starve_cnt=0.
- FORCE entered while d_req drops: illegal, since d_req is held until grant. If it occurs, the arbiter drives no access (m_re=m_we=0), keeps core_stall=1 for that cycle, and returns to NORMAL.
- Read return:
  - A registered flag records a DMA read grant (d_gnt & ~d_we).
  - d_rvalid equals that flag one cycle after the grant; d_rdata=m_rdata.
  - c_rdata=m_rdata always; the core samples it per its own load timing.
- Back-to-back DMA grants in consecutive idle cycles are allowed; d_rvalid can then be high on consecutive cycles.
- core_stall is only ever high in FORCE, never in NORMAL.
- With STARVE_LIMIT=1, a denied DMA cycle is always followed by a FORCE cycle.

Test Plan:
- Core only: c_re=1, c_addr=0x100, m_rdata=0xDEADBEEF the next cycle. Expect m_addr=0x100 and m_re=1 the same cycle; c_rdata=0xDEADBEEF the next cycle; d_gnt=0 and core_stall=0 throughout.
- DMA in idle: core idle, d_req=1, d_we=0, d_addr=0x200. Expect d_gnt=1 the same cycle, then d_rvalid=1 with d_rdata=m_rdata the next cycle. A DMA write of 0x12345678 with d_wstrb=4'b0011 shows m_we=1 and m_wstrb=0011.
- Contention: core active every cycle, d_req=1, STARVE_LIMIT=8. Expect 8 denied cycles, then one cycle with core_stall=1, d_gnt=1 and m_addr=d_addr. The next cycle shows core_stall=0 and the core is serviced again.
- Simultaneous idle grant: core goes idle on cycle 5 of contention. Expect a d_gnt on cycle 5, starve_cnt cleared, and no FORCE cycle afterwards.
- Reset mid-op: assert rst in the cycle after a DMA read grant. Expect d_rvalid=0, core_stall=0, m_re=m_we=0 and starve_cnt=0 the cycle after reset.
- STARVE_LIMIT=1: core busy, d_req=1. Expect FORCE (core_stall=1) on every second cycle, alternating grants between core and DMA.
